// File: rtl/effective_address_unit.sv
// Effective-address unit for PDP-8 memory-reference instructions.
// Resolves page-zero / current-page and direct / indirect addressing. Indirect
// references through the auto-index pointers are read, incremented and
// written back before the address is reported.
module effective_address_unit #(
  parameter logic [11:0] AUTO_INDEX_LO = 12'o0010,
  parameter logic [11:0] AUTO_INDEX_HI = 12'o0017
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] instruction,
  input  logic [11:0] pc,
  output logic        busy,
  output logic        done,
  output logic [11:0] ea,
  output logic        auto_indexed,
  output logic        not_mri,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_read_type,
  output logic        mem_write_enable,
  input  logic [11:0] mem_read_data
);

  // memory_utils read-type encoding for an ordinary data read
  localparam logic READ_DATA = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    IND_READ,
    IND_WAIT,
    AUTO_WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [11:0] instr_q;
  logic [11:0] pc_q;
  logic [11:0] ptr;
  logic [2:0]  opcode;
  logic        is_mri;
  logic        is_indirect;
  logic        is_auto;

  // Decode of the latched instruction; the pointer uses the latched pc page
  assign opcode      = instr_q[11:9];
  assign is_mri      = (opcode < 3'd6);
  assign is_indirect = instr_q[8];
  assign ptr         = instr_q[7] ? {pc_q[11:7], instr_q[6:0]} : {5'b0, instr_q[6:0]};
  // Auto-index is decided on the pointer address alone, whatever the page bit
  assign is_auto     = (ptr >= AUTO_INDEX_LO) && (ptr <= AUTO_INDEX_HI);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = EVAL;
      EVAL:       state_next = (is_mri && is_indirect) ? IND_READ : DONE;
      IND_READ:   state_next = IND_WAIT;
      IND_WAIT:   state_next = is_auto ? AUTO_WRITE : DONE;
      AUTO_WRITE: state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Status and memory strobes decoded from state; reset to IDLE drops them at once
  always_comb begin
    busy             = (state != IDLE);
    done             = (state == DONE);
    mem_read_enable  = (state == IND_READ);
    mem_write_enable = (state == AUTO_WRITE);
    mem_read_type    = READ_DATA;
  end

  // Datapath: request capture, pointer address, write-back data and results
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q        <= '0;
      pc_q           <= '0;
      ea             <= '0;
      auto_indexed   <= 1'b0;
      not_mri        <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            instr_q      <= instruction;
            pc_q         <= pc;
            auto_indexed <= 1'b0;
            not_mri      <= 1'b0;
          end
        end
        EVAL: begin
          if (!is_mri) begin
            ea      <= '0;
            not_mri <= 1'b1;
          end else if (!is_indirect) begin
            ea <= ptr;
          end else begin
            mem_address <= ptr;
          end
        end
        IND_WAIT: begin
          // Incremented pointer wraps modulo 4096; the carry is dropped
          if (is_auto) mem_write_data <= mem_read_data + 12'd1;
          else         ea             <= mem_read_data;
        end
        AUTO_WRITE: begin
          ea           <= mem_write_data;
          auto_indexed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
